// File: rtl/axis_pkt_demux.sv
// Packet-aware AXI-Stream 1:N demultiplexer: the channel is latched at packet start,
// beats pass through a single output slot, and packets with an invalid select are dropped and counted.
module axis_pkt_demux #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 8,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         bus_sel,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]        m_axis_tvalid,
    output logic [NUM_CH-1:0]        m_axis_tlast,
    input  logic [NUM_CH-1:0]        m_axis_tready,
    output logic [CH_W-1:0]          active_ch,
    output logic                     busy,
    output logic [CNT_W-1:0]         drop_cnt
);

    // Handshake: a beat moves on either side only in a cycle where valid and ready are both 1.
    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t             state, state_nxt;
    logic               out_valid;
    logic [DATA_W-1:0]  data_q;
    logic               last_q;
    logic [CH_W-1:0]    ch_out;
    logic [SEL_W-2:0]   sel_idx;
    logic               sel_ok;
    logic               slot_ready;
    logic               load;
    logic               drain;

    assign sel_idx = bus_sel[SEL_W-2:0];
    assign sel_ok  = bus_sel[SEL_W-1] && (32'(sel_idx) < NUM_CH);

    // The slot may still hold the previous packet's last beat on another channel,
    // so acceptance depends on the channel currently occupying the slot.
    assign slot_ready = !out_valid || m_axis_tready[ch_out];
    assign drain      = out_valid && m_axis_tready[ch_out];

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        load          = 1'b0;
        case (state)
            IDLE: begin
                if (s_axis_tvalid) state_nxt = sel_ok ? FWD : DROP;
            end
            FWD: begin
                s_axis_tready = slot_ready;
                load          = s_axis_tvalid && slot_ready;
                if (load && s_axis_tlast) state_nxt = IDLE;
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            active_ch <= '0;
            drop_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && s_axis_tvalid && sel_ok) active_ch <= sel_idx[CH_W-1:0];
            if (state == DROP && s_axis_tvalid && s_axis_tlast && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Load and drain in the same cycle keeps the slot full for back-to-back beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            ch_out    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            data_q    <= s_axis_tdata;
            last_q    <= s_axis_tlast;
            ch_out    <= active_ch;
        end else if (drain) begin
            out_valid <= 1'b0;
            last_q    <= 1'b0;
        end
    end

    always_comb begin
        m_axis_tvalid = '0;
        m_axis_tlast  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_axis_tvalid[k] = out_valid && (ch_out == CH_W'(k));
            m_axis_tlast[k]  = last_q && (ch_out == CH_W'(k));
        end
    end

    assign m_axis_tdata = {NUM_CH{data_q}};
    assign busy         = (state != IDLE) || out_valid;

endmodule

// File: tb/tb_axis_pkt_demux.sv
// Directed bench for axis_pkt_demux: egress beats are checked against an expected queue,
// with a second narrow-counter instance used to reach drop-counter saturation quickly.
module tb_axis_pkt_demux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   bus_sel;
    logic [31:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [255:0] m_tdata;
    logic [7:0]   m_tvalid;
    logic [7:0]   m_tlast;
    logic [7:0]   m_tready;
    logic [2:0]   active_ch;
    logic         busy;
    logic [15:0]  drop_cnt;

    logic         sat_s_tready;
    logic [255:0] sat_m_tdata;
    logic [7:0]   sat_m_tvalid;
    logic [7:0]   sat_m_tlast;
    logic [2:0]   sat_active_ch;
    logic         sat_busy;
    logic [1:0]   sat_drop_cnt;

    logic [7:0]   ready_base;
    logic         tog = 1'b0;
    logic         tog_en;

    int checks   = 0;
    int failures = 0;

    logic [35:0]  exp_q[$];

    logic [7:0]   prev_v;
    logic [31:0]  prev_d;
    logic [7:0]   prev_l;
    logic         prev_stall = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    assign m_tready = tog_en ? {ready_base[7:2], tog, ready_base[0]} : ready_base;

    axis_pkt_demux #(.NUM_CH(8), .DATA_W(32), .SEL_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .active_ch(active_ch), .busy(busy), .drop_cnt(drop_cnt)
    );

    axis_pkt_demux #(.NUM_CH(8), .DATA_W(32), .SEL_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(sat_s_tready),
        .m_axis_tdata(sat_m_tdata), .m_axis_tvalid(sat_m_tvalid), .m_axis_tlast(sat_m_tlast),
        .m_axis_tready(m_tready),
        .active_ch(sat_active_ch), .busy(sat_busy), .drop_cnt(sat_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic l);
        int  n;
        logic hs;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n  = 0;
        hs = 1'b0;
        do begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 100);
        chk("accept_timeout", hs, 1);
    endtask

    task automatic send_pkt(input logic [7:0] sel, input int n, input logic [31:0] base,
                            input int exp_ch, input int chg_beat, input logic [7:0] chg_sel);
        bus_sel = sel;
        for (int i = 0; i < n; i++)
            if (exp_ch >= 0) exp_q.push_back({3'(exp_ch), (i == n - 1), base + 32'(i)});
        for (int i = 0; i < n; i++) begin
            if (i == chg_beat) bus_sel = chg_sel;
            drive_beat(base + 32'(i), (i == n - 1));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        step();
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_queue"}, exp_q.size(), 0);
    endtask

    // Egress monitor: every handshake must match the head of the expected queue,
    // and a stalled beat must hold valid/data/last unchanged.
    always @(negedge clk) begin
        logic [35:0] got;
        int vi;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            vi = 0;
            for (int k = 0; k < 8; k++) if (m_tvalid[k]) vi = k;
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, prev_v);
                chk("stall_data", m_tdata[vi*32 +: 32], prev_d);
                chk("stall_last", m_tlast, prev_l);
            end
            chk("valid_onehot", $onehot0(m_tvalid), 1);
            for (int k = 0; k < 8; k++) begin
                if (m_tvalid[k] && m_tready[k]) begin
                    got = {k[2:0], m_tlast[k], m_tdata[k*32 +: 32]};
                    chk("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("beat_value", got, exp_q.pop_front());
                end
            end
            prev_stall = |(m_tvalid & ~m_tready);
            prev_v     = m_tvalid;
            prev_d     = m_tdata[vi*32 +: 32];
            prev_l     = m_tlast;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        bus_sel    = 8'h00;
        s_tdata    = 32'h0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        ready_base = 8'hFF;
        tog_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata_zero", m_tdata === '0, 1);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active_ch", active_ch, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        step();

        // Streaming 4-beat packet to ch3, one bubble at start, 1-cycle latency per beat.
        for (int i = 0; i < 4; i++) exp_q.push_back({3'd3, (i == 3), 32'hA000_0000 + 32'(i)});
        bus_sel  = 8'h83;
        s_tdata  = 32'hA000_0000;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        chk("t1_idle_not_ready", s_tready, 0);
        step();
        chk("t1_fwd_ready", s_tready, 1);
        chk("t1_active_ch", active_ch, 3);
        chk("t1_bubble_no_valid", m_tvalid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_valid", m_tvalid, 8'h08);
            chk("t1_data", m_tdata[3*32 +: 32], 32'hA000_0000 + 32'(i));
            chk("t1_last", m_tlast, (i == 3) ? 8'h08 : 8'h00);
            if (i < 3) begin
                s_tdata = 32'hA000_0001 + 32'(i);
                s_tlast = (i == 2);
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
        end
        step();
        chk("t1_valid_after", m_tvalid, 0);
        drain("t1");

        // ch1 with its ready toggling every clock.
        tog_en = 1'b1;
        send_pkt(8'h81, 6, 32'hB000_0000, 1, -1, 8'h00);
        drain("t2");
        tog_en = 1'b0;

        // Invalid selects are consumed and counted.
        send_pkt(8'h05, 3, 32'hC000_0000, -1, -1, 8'h00);
        drain("t3a");
        chk("t3_drop1", drop_cnt, 1);
        send_pkt(8'h8A, 3, 32'hC100_0000, -1, -1, 8'h00);
        drain("t3b");
        chk("t3_drop2", drop_cnt, 2);
        chk("t3_sat_drop2", sat_drop_cnt, 2);
        send_pkt(8'h88, 1, 32'hC200_0000, -1, -1, 8'h00);
        drain("t3c");
        chk("t3_drop3_idx_eq_num_ch", drop_cnt, 3);

        // Mid-packet select change is ignored; the next packet uses the new select.
        send_pkt(8'h80, 4, 32'hD000_0000, 0, 2, 8'h82);
        drain("t4a");
        send_pkt(8'h82, 2, 32'hD100_0000, 2, -1, 8'h00);
        drain("t4b");
        chk("t4_active_ch", active_ch, 2);

        // ch0 last beat stuck in the slot blocks the following ch7 packet.
        ready_base = 8'hFE;
        send_pkt(8'h80, 1, 32'hE000_0000, 0, -1, 8'h00);
        exp_q.push_back({3'd7, 1'b0, 32'hF000_0000});
        exp_q.push_back({3'd7, 1'b1, 32'hF000_0001});
        bus_sel  = 8'h87;
        s_tdata  = 32'hF000_0000;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        repeat (3) step();
        chk("t5_ch0_held", m_tvalid, 8'h01);
        chk("t5_ch0_data", m_tdata[31:0], 32'hE000_0000);
        chk("t5_ingress_blocked", s_tready, 0);
        chk("t5_active_ch", active_ch, 7);
        chk("t5_busy", busy, 1);
        ready_base = 8'hFF;
        drive_beat(32'hF000_0000, 1'b0);
        drive_beat(32'hF000_0001, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drain("t5");

        // Reset mid-packet clears everything; the pending beat is lost.
        bus_sel  = 8'h83;
        s_tdata  = 32'h1111_0000;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", m_tvalid, 0);
        chk("t6_rst_tlast", m_tlast, 0);
        chk("t6_rst_s_tready", s_tready, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_active_ch", active_ch, 0);
        chk("t6_rst_drop_cnt", drop_cnt, 0);
        chk("t6_rst_tdata_zero", m_tdata === '0, 1);
        bus_sel = 8'h85;
        s_tdata = 32'h2222_0000;
        s_tlast = 1'b1;
        step();
        rst_n = 1'b1;
        exp_q.push_back({3'd5, 1'b1, 32'h2222_0000});
        drive_beat(32'h2222_0000, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("t6_restart_ch", active_ch, 5);
        drain("t6");

        // Drop-counter saturation on the 2-bit instance.
        send_pkt(8'h00, 1, 32'h3000_0000, -1, -1, 8'h00);
        send_pkt(8'h7F, 1, 32'h3000_0001, -1, -1, 8'h00);
        send_pkt(8'hFF, 1, 32'h3000_0002, -1, -1, 8'h00);
        drain("t7a");
        chk("t7_drop3", drop_cnt, 3);
        chk("t7_sat_drop3", sat_drop_cnt, 3);
        send_pkt(8'h90, 1, 32'h3000_0003, -1, -1, 8'h00);
        drain("t7b");
        chk("t7_drop4", drop_cnt, 4);
        chk("t7_sat_hold", sat_drop_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
